// File: rtl/instr_sequencer_pkg.sv
// Shared constants and state type for the instruction sequencer.
// Optional single-step support is selected with SEQ_SINGLE_STEP_EN.
package seq_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_RD,
    ST_EXEC,
    ST_MEM_WR,
    ST_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , ST_STEP_WAIT
`endif
  } state_e;

endpackage

// File: rtl/instr_sequencer_opdec.sv
// Combinational opcode-class decoder; opcodes A-E and NOP fall through
// with every class flag low.
module seq_opdec
  import seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  output logic            is_mem_rd,
  output logic            is_mem_wr,
  output logic            is_alu_only,
  output logic            is_jmp,
  output logic            is_jz,
  output logic            is_halt
);

  always_comb begin
    is_mem_rd   = 1'b0;
    is_mem_wr   = 1'b0;
    is_alu_only = 1'b0;
    is_jmp      = 1'b0;
    is_jz       = 1'b0;
    is_halt     = 1'b0;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: is_mem_rd   = 1'b1;
      OP_STA:                                is_mem_wr   = 1'b1;
      OP_NOT:                                is_alu_only = 1'b1;
      OP_JMP:                                is_jmp      = 1'b1;
      OP_JZ:                                 is_jz       = 1'b1;
      OP_HALT:                               is_halt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator CPU; owns PC and IR.
// Define SEQ_SINGLE_STEP_EN to add step_en/step ports and the STEP_WAIT state.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_en,
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic              dmem_ack,
  input  logic              acc_zero,
  output logic [OP_W-1:0]   alu_op,
  output logic              acc_we,
  output logic              halted
);

  state_e              state_q, state_d, fetch_st;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_rd_q, dmem_rd_d;
  logic                dmem_wr_q, dmem_wr_d;
  logic                acc_we_q, acc_we_d;
  logic                halted_q, halted_d;

  logic [OP_W-1:0]     opcode;
  logic [3:0]          unused_rsvd;
  logic                is_mem_rd, is_mem_wr, is_alu_only, is_jmp, is_jz, is_halt;

  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign unused_rsvd = ir_q[11:8];

  seq_opdec #(.OP_W(OP_W)) u_opdec (
    .opcode      (opcode),
    .is_mem_rd   (is_mem_rd),
    .is_mem_wr   (is_mem_wr),
    .is_alu_only (is_alu_only),
    .is_jmp      (is_jmp),
    .is_jz       (is_jz),
    .is_halt     (is_halt)
  );

  always_comb begin
    // Every edge that would enter FETCH is routed through this target so
    // single-step can intercept all of them in one place.
    fetch_st = ST_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
    if (step_en) fetch_st = ST_STEP_WAIT;
`endif
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = fetch_st;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_halt)          state_d = ST_HALT;
        else if (is_mem_rd)   state_d = ST_MEM_RD;
        else if (is_mem_wr)   state_d = ST_MEM_WR;
        else if (is_alu_only) state_d = ST_EXEC;
        else begin
          if (is_jmp || (is_jz && acc_zero)) pc_d = ir_q[ADDR_MSB:ADDR_LSB];
          state_d = fetch_st;
        end
      end
      ST_MEM_RD: if (dmem_ack) state_d = ST_EXEC;
      ST_EXEC:   state_d = fetch_st;
      ST_MEM_WR: if (dmem_ack) state_d = fetch_st;
      ST_HALT:   state_d = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      ST_STEP_WAIT: if (step) state_d = ST_FETCH;
`endif
      default:   state_d = ST_IDLE;
    endcase

    // Moore outputs registered from the next state so they line up with state_q.
    imem_req_d = (state_d == ST_FETCH);
    dmem_rd_d  = (state_d == ST_MEM_RD);
    dmem_wr_d  = (state_d == ST_MEM_WR);
    acc_we_d   = (state_d == ST_EXEC);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_rd_q  <= 1'b0;
      dmem_wr_q  <= 1'b0;
      acc_we_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      dmem_rd_q  <= dmem_rd_d;
      dmem_wr_q  <= dmem_wr_d;
      acc_we_q   <= acc_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = imem_req_q;
  assign dmem_addr = ir_q[ADDR_MSB:ADDR_LSB];
  assign dmem_rd   = dmem_rd_q;
  assign dmem_wr   = dmem_wr_q;
  assign alu_op    = opcode;
  assign acc_we    = acc_we_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: an instruction-level model emits the
// expected per-cycle outputs into a queue that a single compare process checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, imem_ack, dmem_ack, acc_zero;
  logic [15:0] instr;
  logic [7:0]  imem_addr, dmem_addr;
  logic        imem_req, dmem_rd, dmem_wr, acc_we, halted;
  logic [3:0]  alu_op;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_en, step;
`endif

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(8), .OP_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_en   (step_en),
    .step      (step),
`endif
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .instr     (instr),
    .dmem_addr (dmem_addr),
    .dmem_rd   (dmem_rd),
    .dmem_wr   (dmem_wr),
    .dmem_ack  (dmem_ack),
    .acc_zero  (acc_zero),
    .alu_op    (alu_op),
    .acc_we    (acc_we),
    .halted    (halted)
  );

  typedef struct packed {
    logic       req;
    logic [7:0] iaddr;
    logic       rd;
    logic       wr;
    logic [7:0] daddr;
    logic       we;
    logic       hlt;
    logic [3:0] op;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_step;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t mk(bit req, bit rd, bit wr, bit we, bit hlt);
    exp_t e;
    e.req   = req;
    e.iaddr = m_pc;
    e.rd    = rd;
    e.wr    = wr;
    e.daddr = m_ir[7:0];
    e.we    = we;
    e.hlt   = hlt;
    e.op    = m_ir[15:12];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, acc_we, halted, alu_op};
      check("outputs{req,iaddr,rd,wr,daddr,we,hlt,op}", 32'(a), 32'(e));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    acc_zero = 1'($urandom);
    start    = 1'($urandom);
    instr    = 16'($urandom);
  endtask

  // Reset edge with start and both acks high; the next cycle must still be idle.
  task automatic do_reset();
    reset = 1'b1; start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc  = 8'h00;
    m_ir  = 16'h0000;
    noise(); start = 1'b0;
    tick(mk(0, 0, 0, 0, 0));
  endtask

  task automatic do_start();
    noise(); start = 1'b1;
    tick(mk(0, 0, 0, 0, 0));
    start = 1'b0;
  endtask

  task automatic step_gate();
`ifdef SEQ_SINGLE_STEP_EN
    if (m_step) begin
      repeat (3) begin noise(); step = 1'b0; tick(mk(0, 0, 0, 0, 0)); end
      noise(); step = 1'b1;
      tick(mk(0, 0, 0, 0, 0));
      step = 1'b0;
    end
`endif
  endtask

  // One instruction from FETCH entry: fw fetch wait cycles, dw data wait
  // cycles, az = acc_zero at decode, abort_at = data-wait index to reset on.
  task automatic run_instr(input logic [15:0] w, input int fw, input int dw,
                           input bit az, input int abort_at, output bit aborted);
    logic [3:0] op;
    bit isrd, iswr;
    aborted = 1'b0;
    op   = w[15:12];
    isrd = (op == 4'h1) || (op == 4'h3) || (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
    iswr = (op == 4'h2);
    step_gate();
    repeat (fw) begin noise(); imem_ack = 1'b0; tick(mk(1, 0, 0, 0, 0)); end
    noise(); imem_ack = 1'b1; instr = w;
    tick(mk(1, 0, 0, 0, 0));
    m_ir = w;
    m_pc = m_pc + 8'd1;
    noise(); acc_zero = az;
    tick(mk(0, 0, 0, 0, 0));
    if (isrd || iswr) begin
      for (int i = 0; i <= dw; i++) begin
        noise();
        dmem_ack = (i == dw);
        if (i == abort_at) reset = 1'b1;
        tick(mk(0, isrd, iswr, 0, 0));
        if (reset) begin
          reset = 1'b0; m_pc = 8'h00; m_ir = 16'h0000; aborted = 1'b1;
          return;
        end
      end
      if (isrd) begin noise(); tick(mk(0, 0, 0, 1, 0)); end
    end else if (op == 4'h7) begin
      noise(); tick(mk(0, 0, 0, 1, 0));
    end else if (op == 4'h8) begin
      m_pc = w[7:0];
    end else if (op == 4'h9 && az) begin
      m_pc = w[7:0];
    end
  endtask

  initial begin
    bit ab;
    logic [3:0] op;
    int dw;
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    acc_zero = 1'b0; instr = 16'h0000; m_step = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000;
`ifdef SEQ_SINGLE_STEP_EN
    step_en = 1'b0; step = 1'b0;
`endif
    do_reset();
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    do_start();
    for (int i = 0; i < 3; i++) run_instr(16'h0000, 0, 0, 1'b0, -1, ab);
    check("nop_pc_after3", 32'(imem_addr), 32'h03);

    run_instr(16'h3020, 0, 3, 1'b0, -1, ab);
    check("add_next_pc", 32'(imem_addr), 32'h04);
    check("add_alu_op", 32'(alu_op), 32'h3);

    run_instr(16'h9040, 0, 0, 1'b1, -1, ab);
    check("jz_taken_pc", 32'(imem_addr), 32'h40);
    do_reset();
    do_start();
    run_instr(16'h9040, 1, 0, 1'b0, -1, ab);
    check("jz_not_taken_pc", 32'(imem_addr), 32'h01);

    run_instr(16'h80FF, 0, 0, 1'b0, -1, ab);
    check("jmp_ff_pc", 32'(imem_addr), 32'hFF);
    run_instr(16'h0000, 2, 0, 1'b0, -1, ab);
    check("pc_wrap", 32'(imem_addr), 32'h00);

    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) run_instr(16'h0000, 0, 0, 1'b0, -1, ab);
    run_instr(16'hF000, 0, 0, 1'b0, -1, ab);
    repeat (6) begin noise(); tick(mk(0, 0, 0, 0, 1)); end
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(imem_addr), 32'h06);
    do_reset();
    check("halt_cleared", 32'(halted), 32'h0);
    check("halt_reset_pc", 32'(imem_addr), 32'h00);

    do_start();
    run_instr(16'h0000, 0, 0, 1'b0, -1, ab);
    run_instr(16'h2033, 0, 5, 1'b0, 2, ab);
    check("midreset_aborted", 32'(ab), 32'h1);
    check("midreset_wr_low", 32'(dmem_wr), 32'h0);
    check("midreset_pc", 32'(imem_addr), 32'h00);
    repeat (2) begin noise(); start = 1'b0; tick(mk(0, 0, 0, 0, 0)); end

    do_start();
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 14));
      dw = $urandom_range(0, 3);
      run_instr({op, 4'($urandom), 8'($urandom)}, $urandom_range(0, 2), dw, 1'($urandom),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, dw) : -1, ab);
      if (ab) do_start();
    end

`ifdef SEQ_SINGLE_STEP_EN
    do_reset();
    m_step = 1'b1; step_en = 1'b1;
    do_start();
    for (int n = 0; n < 20; n++)
      run_instr({4'($urandom_range(0, 9)), 4'h0, 8'($urandom)}, $urandom_range(0, 1),
                $urandom_range(0, 2), 1'($urandom), -1, ab);
    step_gate();
    m_step = 1'b0; step_en = 1'b0;
    run_instr(16'h0000, 0, 0, 1'b0, -1, ab);
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
